// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the n-bit stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// PORT_A / PORT_B  : encodings of the per-beat select bit.
// FIFO_DEPTH       : entries per output port FIFO.
// COUNT_W          : width of the optional accepted-beat counters.
// ptr_next()       : FIFO pointer increment with wrap at FIFO_DEPTH-1.
package demux_pkg;

  localparam logic PORT_A     = 1'b0;
  localparam logic PORT_B     = 1'b1;
  localparam int   FIFO_DEPTH = 2;
  localparam int   COUNT_W    = 16;

  // Pointer indexes one of FIFO_DEPTH slots; occupancy must also represent "full".
  localparam int   PTR_W      = $clog2(FIFO_DEPTH);
  localparam int   OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  // Advance a FIFO pointer, wrapping the last slot back to slot 0.
  function automatic ptr_t ptr_next(input ptr_t p);
    ptr_t nxt;
    if (p == ptr_t'(FIFO_DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = p + ptr_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/demux_port_fifo.sv
// Per-port output FIFO (FIFO_DEPTH entries) feeding one consumer of the demux.
// Latency: a beat pushed at edge k is visible on pop_vld/pop_dat from cycle k+1.
// Backpressure: full is high at occupancy FIFO_DEPTH; a pop does not free space until the next cycle.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push_vld, push_dat : write request and payload (caller must not push while full)
//   full               : no free entry this cycle
//   pop_rdy            : consumer ready; a pop happens when pop_vld && pop_rdy
//   pop_vld, pop_dat   : head entry present / head entry payload (driven from registers)
module demux_port_fifo
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [n-1:0] push_dat,
  output logic         full,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [n-1:0] pop_dat
);

  logic [n-1:0] mem_q [FIFO_DEPTH];
  ptr_t         head_q;
  ptr_t         tail_q;
  occ_t         occ_q;

  logic         do_push;
  logic         do_pop;

  assign full    = (occ_q == occ_t'(FIFO_DEPTH));
  assign pop_vld = (occ_q != '0);

  // Head data is a mux of storage registers only, so there is no
  // combinational path from the input payload to the output payload.
  assign pop_dat = mem_q[head_q];

  // Full blocks the push even when a pop happens in the same cycle; the
  // freed slot is only offered to the producer on the following cycle.
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= push_dat;
        tail_q        <= ptr_next(tail_q);
      end
      if (do_pop) begin
        head_q <= ptr_next(head_q);
      end
      // Simultaneous push and pop keeps occupancy; both pointers still move.
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + occ_t'(1);
        2'b01:   occ_q <= occ_q - occ_t'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // The parent gates pushes with its ready, so a push request while full
  // means the ready logic upstream is broken.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) push_vld |-> !full
  );

  a_occ_in_range: assert property (
    @(posedge clk) disable iff (!rst_n) occ_q <= occ_t'(FIFO_DEPTH)
  );

endmodule

// File: rtl/n_bit_demux.sv
// Two-port stream demux: each input beat is steered by in_sel to port A (0) or port B (1).
// Latency: beat accepted at edge k is visible on X_valid/X_data in cycle k+1.
// Backpressure: in_ready follows only the selected port's FIFO fullness; a stalled port never blocks the other.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_data, in_sel, in_valid    : input beat, destination select, beat present
//   in_ready                     : input beat accepted this cycle (when in_valid)
//   A_data, A_valid, A_ready     : port A output stream
//   B_data, B_valid, B_ready     : port B output stream
//   A_count, B_count             : accepted-beat counters per port, wrap at 16'hFFFF
//                                  (present only when N_BIT_DEMUX_COUNT_EN is defined)
//
// Build option: define N_BIT_DEMUX_COUNT_EN to add the per-port accepted-beat counters.
module n_bit_demux
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [n-1:0]       in_data,
  input  logic               in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [n-1:0]       A_data,
  output logic               A_valid,
  input  logic               A_ready,
  output logic [n-1:0]       B_data,
  output logic               B_valid,
  input  logic               B_ready
`ifdef N_BIT_DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] A_count,
  output logic [COUNT_W-1:0] B_count
`endif
);

  logic a_full;
  logic b_full;
  logic in_fire;
  logic a_push_vld;
  logic b_push_vld;

  // Ready depends only on the selected destination's occupancy, never on the
  // consumer readies, so a changing in_sel simply re-evaluates against the
  // other FIFO in the same cycle.
  assign in_ready   = (in_sel == PORT_B) ? !b_full : !a_full;
  assign in_fire    = in_valid && in_ready;

  assign a_push_vld = in_fire && (in_sel == PORT_A);
  assign b_push_vld = in_fire && (in_sel == PORT_B);

  demux_port_fifo #(
    .n (n)
  ) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (a_push_vld),
    .push_dat (in_data),
    .full     (a_full),
    .pop_rdy  (A_ready),
    .pop_vld  (A_valid),
    .pop_dat  (A_data)
  );

  demux_port_fifo #(
    .n (n)
  ) u_fifo_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (b_push_vld),
    .push_dat (in_data),
    .full     (b_full),
    .pop_rdy  (B_ready),
    .pop_vld  (B_valid),
    .pop_dat  (B_data)
  );

`ifdef N_BIT_DEMUX_COUNT_EN
  // Count beats accepted on the input side, per destination; the counters
  // wrap naturally at their width.
  logic [COUNT_W-1:0] a_count_q;
  logic [COUNT_W-1:0] b_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (a_push_vld) begin
        a_count_q <= a_count_q + COUNT_W'(1);
      end
      if (b_push_vld) begin
        b_count_q <= b_count_q + COUNT_W'(1);
      end
    end
  end

  assign A_count = a_count_q;
  assign B_count = b_count_q;
`else
  // Counters not built: no count ports and no count state.
`endif

endmodule

// File: tb/tb_n_bit_demux.sv
// Self-checking bench for n_bit_demux: reset, steering, backpressure, full-with-pop,
// streaming, reset with buffered beats, and (when N_BIT_DEMUX_COUNT_EN) counter wrap.
// Inputs change 1 time unit after a rising edge; outputs are checked at the falling edge.
module tb_n_bit_demux;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A_data;
  logic         A_valid;
  logic         A_ready;
  logic [N-1:0] B_data;
  logic         B_valid;
  logic         B_ready;
`ifdef N_BIT_DEMUX_COUNT_EN
  logic [15:0]  A_count;
  logic [15:0]  B_count;
`endif

  int errors = 0;
  int checks = 0;

  n_bit_demux #(
    .n (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A_data   (A_data),
    .A_valid  (A_valid),
    .A_ready  (A_ready),
    .B_data   (B_data),
    .B_valid  (B_valid),
    .B_ready  (B_ready)
`ifdef N_BIT_DEMUX_COUNT_EN
    ,
    .A_count  (A_count),
    .B_count  (B_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector = inputs for a cycle plus the outputs expected in that same
  // cycle (in_ready for these inputs, and the buffered state from earlier edges).
  typedef struct {
    logic         vld;
    logic         sel;
    logic [N-1:0] dat;
    logic         ar;
    logic         br;
    logic         e_rdy;
    logic         e_av;
    logic [N-1:0] e_ad;
    logic         e_bv;
    logic [N-1:0] e_bd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic sel, input logic [N-1:0] dat,
                       input logic ar, input logic br);
    in_valid = vld;
    in_sel   = sel;
    in_data  = dat;
    A_ready  = ar;
    B_ready  = br;
  endtask

  initial begin
    // Steering: 11 -> A, 22 -> B.
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1,  1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 8'h22};
    // Backpressure isolation: A stalled, 01/02 fill A, 03 refused, B0 passes to B.
    vecs[3]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1,  1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1,  1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1,  1'b0, 1'b1, 8'h01, 1'b1, 8'hB0};
    // Full with pop: ready low during the pop cycle, 03 accepted the cycle after.
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1,  1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1,  1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    // Mirror case: B stalled and full, A still flows.
    vecs[12] = '{1'b1, 1'b1, 8'hC1, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 1'b1, 8'hC2, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b1, 8'hC1};
    vecs[14] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b0,  1'b0, 1'b0, 8'h00, 1'b1, 8'hC1};
    vecs[15] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b1, 8'hC1};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1,  1'b0, 1'b1, 8'hA5, 1'b1, 8'hC1};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 8'hC2};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

    // ---- Reset held with a beat offered ----
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 32'(A_valid), 32'd0);
    check("rst_b_valid", 32'(B_valid), 32'd0);
    check("rst_a_data",  32'(A_data),  32'd0);
    check("rst_b_data",  32'(B_data),  32'd0);
`ifdef N_BIT_DEMUX_COUNT_EN
    check("rst_a_count", 32'(A_count), 32'd0);
    check("rst_b_count", 32'(B_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_a_valid", 32'(A_valid), 32'd0);
    check("post_rst_b_valid", 32'(B_valid), 32'd0);
    @(posedge clk);
    #1;

    // ---- Directed vector table ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].dat, vecs[i].ar, vecs[i].br);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_a_valid", i),  32'(A_valid),  32'(vecs[i].e_av));
      check($sformatf("v%0d_b_valid", i),  32'(B_valid),  32'(vecs[i].e_bv));
      if (vecs[i].e_av) check($sformatf("v%0d_a_data", i), 32'(A_data), 32'(vecs[i].e_ad));
      if (vecs[i].e_bv) check($sformatf("v%0d_b_data", i), 32'(B_data), 32'(vecs[i].e_bd));
      @(posedge clk);
      #1;
    end

    // ---- Streaming: 16 beats alternating ports, both consumers ready ----
    for (int i = 0; i <= 16; i++) begin
      logic [N-1:0] exp_d;
      logic         psel;
      if (i < 16) drive(1'b1, i[0], 8'(8'h40 + i), 1'b1, 1'b1);
      else        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      if (i < 16) check($sformatf("s%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i == 0) begin
        check("s0_a_valid", 32'(A_valid), 32'd0);
        check("s0_b_valid", 32'(B_valid), 32'd0);
      end else begin
        psel  = (i % 2) == 0;
        exp_d = 8'(8'h40 + i - 1);
        check($sformatf("s%0d_a_valid", i), 32'(A_valid), 32'(!psel));
        check($sformatf("s%0d_b_valid", i), 32'(B_valid), 32'(psel));
        check($sformatf("s%0d_data", i), 32'(psel ? B_data : A_data), 32'(exp_d));
      end
      @(posedge clk);
      #1;
    end

    // ---- Reset with beats buffered in both FIFOs ----
    drive(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 8'hD3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_a_valid", 32'(A_valid), 32'd1);
    check("pre_rst_b_valid", 32'(B_valid), 32'd1);
    check("pre_rst_a_full",  32'(in_ready && !in_sel), 32'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_a_valid", 32'(A_valid), 32'd0);
    check("mid_rst_b_valid", 32'(B_valid), 32'd0);
    check("mid_rst_a_data",  32'(A_data),  32'd0);
    check("mid_rst_b_data",  32'(B_data),  32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef N_BIT_DEMUX_COUNT_EN
    check("mid_rst_a_count", 32'(A_count), 32'd0);
    check("mid_rst_b_count", 32'(B_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("rel_a_valid", 32'(A_valid), 32'd0);
    check("rel_b_valid", 32'(B_valid), 32'd0);
    @(posedge clk);
    #1;

`ifdef N_BIT_DEMUX_COUNT_EN
    // ---- Counter wrap: 65537 beats to B ----
    drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_b_after3", 32'(B_count), 32'd3);
    repeat (65534) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("cnt_b_wrap", 32'(B_count), 32'd1);
    check("cnt_a_zero", 32'(A_count), 32'd0);
    @(posedge clk);
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_bit_demux.md
# n_bit_demux

Two-port stream demultiplexer, the inverse of our n-bit 2:1 selector: one n-bit input stream is steered by a per-beat select bit to port A (S=0) or port B (S=1). Each output port has a 2-entry FIFO so a stalled port never blocks beats headed to the other port. It sits between a single producer and two independent consumers in the lab datapath/testbench fabric, all in one clock domain.

## Interface
- `n`, default 8: data width in bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input n: input beat payload.
- `in_sel` input 1: destination; 0 = port A, 1 = port B. Qualified by `in_valid`.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block accepts the beat this cycle.
- `A_data` output n, `A_valid` output 1, `A_ready` input 1: port A stream.
- `B_data` output n, `B_valid` output 1, `B_ready` input 1: port B stream.
- `A_count` output 16, `B_count` output 16: accepted-beat counters (only with `N_BIT_DEMUX_COUNT_EN`).

## Operation
- Transfer on any port occurs when valid and ready are both high at a rising `clk` edge.
- `in_ready` = (`in_sel` ? B FIFO not full : A FIFO not full); it depends only on `in_sel` and the selected FIFO occupancy, never on `A_ready`/`B_ready`.
- An accepted input beat is pushed into the selected FIFO only; the other FIFO is untouched.
- Each FIFO: depth 2, occupancy 0/1/2, head/tail pointers 1 bit each, wrapping 1→0.
- `X_valid` = occupancy ≠ 0; `X_data` = head entry, registered (no combinational path from `in_data`).
- Pop on `X_valid && X_ready`; push on input transfer to that port; simultaneous push and pop leaves occupancy unchanged, both pointers advance.
- When full (occupancy 2), no push occurs even if a pop happens the same cycle (`in_ready` was already low).
- Per-port ordering is preserved; no ordering guarantee between ports.
- `in_sel` changing while `in_valid` is high and `in_ready` low is legal; `in_ready` re-evaluates for the new destination.
- Reset (asserted any time, including mid-transfer): occupancies 0, pointers 0, storage 0, `A_valid`/`B_valid` 0, `A_data`/`B_data` 0, counters 0. Buffered beats are discarded.

## Timing
- Latency: beat accepted at edge k appears on `X_valid`/`X_data` after edge k (visible in cycle k+1).
- Throughput: 1 beat/cycle per port when the consumer keeps ready high; sustained 1 beat/cycle on input.
- Full FIFO → `in_ready` low for that destination until the cycle after a pop.
- Reset release is synchronised by the surrounding design; block acts on the first edge with `rst_n` high.

## Configuration
- `N_BIT_DEMUX_COUNT_EN` defined: `A_count`/`B_count` present; each increments by 1 on every accepted input beat for its port, wraps 16'hFFFF→0, reset 0.
- Not defined: ports `A_count`/`B_count` and their logic are absent; all other behaviour identical.

## Structure
- Shared package `demux_pkg`: `PORT_A = 1'b0`, `PORT_B = 1'b1`, `FIFO_DEPTH = 2`, `COUNT_W = 16`.
- Sub-module `demux_port_fifo` (parameter `n`): 2-entry FIFO with push/full, pop/valid/data, async active-low reset; instantiated twice.
- Top level holds select decode, `in_ready` mux, and optional counters.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `in_ready` may be high but `A_valid`=`B_valid`=0, data 0, counters 0; release → outputs stay 0 until a beat is accepted.
- Steering: send 8'h11 sel=0, 8'h22 sel=1, both readies high → next cycle `A_data`=8'h11, then `B_data`=8'h22, each valid one cycle.
- Backpressure isolation: `A_ready`=0, send 3 beats to A (8'h01,8'h02,8'h03) → first two accepted, `in_ready` low on third; meanwhile 8'hB0 to B accepted and delivered.
- Full with pop: A full, raise `A_ready` while holding third beat → 8'h01 out, `in_ready` high next cycle, 8'h03 accepted; order 01,02,03 preserved.
- Streaming: 16 back-to-back beats alternating sel, both readies high → all accepted with `in_ready` never low, 1-cycle latency each.
- Counters (macro on): 65537 beats to B → `B_count`=1 after wrap, `A_count`=0; reset mid-stream with beats buffered → all counts and valids 0.
